i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_sync_edge.sv | 65 ++++++
 rtl/i2c_slave.sv | 194 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target
package i2c_pkg;

    localparam int ADDR_W = 7;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_t;

    // The general-call address (all zeros) is never claimed, even if own address is zero
    function automatic logic addr_hit(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] own);
        return (addr == own) && (addr != '0);
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - bus line synchronizer with edge detect (optional I2C_SLAVE_GLITCH_FILTER_EN)
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   filt;
    logic                   prev_q;

    // Synchronizer chain; resets to the idle-high bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] win_q;
    logic       filt_q;
    logic [2:0] window;

    assign window = {win_q, sync_out};

    // 3-sample majority vote: a single-clk spike never wins, a real change lands 2 clk later
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q  <= '1;
            filt_q <= 1'b1;
        end else begin
            win_q  <= {win_q[0], sync_out};
            filt_q <= (window[0] & window[1]) | (window[0] & window[2]) | (window[1] & window[2]);
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_out;
`endif

    // Previous level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= filt;
        end
    end

    assign level = filt;
    assign rise  = filt & ~prev_q;
    assign fall  = ~filt & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target with byte rx/tx handshake (optional I2C_SLAVE_GLITCH_FILTER_EN)
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLV_ADDR    = 7'h05,
    parameter int                SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    i2c_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       oe_q, oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk   (clk),
        .rst   (rst),
        .din   (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk   (clk),
        .rst   (rst),
        .din   (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    // An SDA edge coinciding with an SCL rise is a data change, never START/STOP
    assign start_cond = sda_fall & scl_lvl & ~scl_rise;
    assign stop_cond  = sda_rise & scl_lvl & ~scl_rise;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rw_q       <= I2C_RW_WRITE;
            oe_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            oe_q       <= oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    // Bus protocol: bits sampled on SCL rise, SDA only moved on SCL fall
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        oe_d       = oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_cond) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop_cond) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        rw_d = shift_q[0];
                        if (addr_hit(shift_q[7:1], SLV_ADDR)) begin
                            state_d = ST_ADDR_ACK;
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q == I2C_RW_READ) begin
                            state_d  = ST_RD_DATA;
                            shift_d  = tx_data;
                            tx_req_d = 1'b1;
                            oe_d     = ~tx_data[7];
                        end else begin
                            state_d = ST_WR_DATA;
                            oe_d    = 1'b0;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = ST_WR_ACK;
                        oe_d       = 1'b1;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_d = ST_WR_DATA;
                        cnt_d   = '0;
                        oe_d    = 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = ST_RD_ACK;
                            oe_d    = 1'b0;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && sda_lvl) begin
                        state_d = ST_IGNORE;
                    end else if (scl_fall) begin
                        state_d  = ST_RD_DATA;
                        cnt_d    = '0;
                        shift_d  = tx_data;
                        tx_req_d = 1'b1;
                        oe_d     = ~tx_data[7];
                    end
                end
                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe   = oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - self-checking bench for i2c_slave (I2C_SLAVE_GLITCH_FILTER_EN aware)
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam logic [6:0] OWN = 7'h05;
    localparam int         Q   = 6;

    logic       clk;
    logic       rst;
    logic       en;
    logic       m_scl;
    logic       m_sda;
    wire        sda;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int n_rxv  = 0;
    int n_txr  = 0;
    int n_oe   = 0;

    logic [7:0] wr_buf [4];
    logic [7:0] tx_buf [4];
    logic [7:0] rd_buf [4];
    logic [7:0] model_rx;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        int         n;
        logic [7:0] d0;
        logic [7:0] exp_rd0;
        logic       exp_aack;
        logic [7:0] exp_rx;
        int         exp_rxv;
        int         exp_txr;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [7];

    assign sda = ~sda_oe & m_sda;

    i2c_slave #(.SLV_ADDR(OWN), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .scl_i    (m_scl),
        .sda_i    (sda),
        .sda_oe   (sda_oe),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) n_rxv++;
        if (tx_req)   n_txr++;
        if (sda_oe)   n_oe++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        m_sda = 1'b1; hold(Q);
        m_scl = 1'b1; hold(Q);
        m_sda = 1'b0; hold(Q);
        m_scl = 1'b0; hold(Q);
    endtask

    task automatic bus_stop;
        m_sda = 1'b0; hold(Q);
        m_scl = 1'b1; hold(Q);
        m_sda = 1'b1; hold(Q);
    endtask

    task automatic put_bit(input logic b);
        m_sda = b;    hold(Q);
        m_scl = 1'b1; hold(2 * Q);
        m_scl = 1'b0; hold(Q);
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; hold(Q);
        m_scl = 1'b1; hold(Q);
        b = sda;      hold(Q);
        m_scl = 1'b0; hold(Q);
    endtask

    task automatic put_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
    endtask

    task automatic xfer(input logic [6:0] a, input logic rw, input int n, input logic do_stop,
                        output logic aack, output int wacks, output logic bsy);
        logic b;
        wacks   = 0;
        tx_data = tx_buf[0];
        bus_start;
        put_byte({a, rw});
        get_bit(b);
        aack = ~b;
        bsy  = busy;
        if (aack) begin
            for (int k = 0; k < n; k++) begin
                if (rw == I2C_RW_WRITE) begin
                    put_byte(wr_buf[k]);
                    get_bit(b);
                    if (!b) wacks++;
                end else begin
                    for (int i = 7; i >= 0; i--) begin
                        get_bit(b);
                        rd_buf[k][i] = b;
                    end
                    if (k < 3) tx_data = tx_buf[k + 1];
                    put_bit(k == n - 1);
                end
            end
        end
        if (do_stop) bus_stop;
    endtask

    task automatic run_check(input string tag, input logic [6:0] a, input logic rw, input int n,
                             input logic e_aack, input logic [7:0] e_rx, input int e_rxv,
                             input int e_txr, input logic e_busy);
        int   rxv0, txr0, oe0, wacks;
        logic aack, bsy;
        rxv0 = n_rxv;
        txr0 = n_txr;
        oe0  = n_oe;
        xfer(a, rw, n, 1'b1, aack, wacks, bsy);
        check({tag, ".aack"}, aack, e_aack);
        check({tag, ".wacks"}, wacks, (e_aack && rw == I2C_RW_WRITE) ? n : 0);
        check({tag, ".rx_data"}, rx_data, e_rx);
        check({tag, ".rx_valid_cnt"}, n_rxv - rxv0, e_rxv);
        check({tag, ".tx_req_cnt"}, n_txr - txr0, e_txr);
        check({tag, ".busy_mid"}, bsy, e_busy);
        check({tag, ".busy_end"}, busy, 1'b0);
        check({tag, ".oe_end"}, sda_oe, 1'b0);
        if (!e_aack) check({tag, ".oe_cycles"}, n_oe - oe0, 0);
        if (e_aack && rw == I2C_RW_READ) begin
            for (int k = 0; k < n; k++) check($sformatf("%s.rd%0d", tag, k), rd_buf[k], tx_buf[k]);
        end
    endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    task automatic put_bit_glitch(input logic b);
        m_sda = b;    hold(Q);
        m_scl = 1'b1; hold(Q);
        m_sda = ~b;   hold(1);
        m_sda = b;    hold(Q - 1);
        m_scl = 1'b0; hold(Q);
    endtask
`endif

    initial begin
        logic b;
        logic aack, bsy;
        int   wacks, rxv0, txr0;
        logic [7:0] gl;

        vecs[0] = '{7'h05, I2C_RW_WRITE, 1, 8'h81, 8'h00, 1'b1, 8'h81, 1, 0, 1'b1};
        vecs[1] = '{7'h05, I2C_RW_READ,  1, 8'hC6, 8'hC6, 1'b1, 8'h81, 0, 1, 1'b1};
        vecs[2] = '{7'h07, I2C_RW_WRITE, 1, 8'h55, 8'h00, 1'b0, 8'h81, 0, 0, 1'b0};
        vecs[3] = '{7'h00, I2C_RW_WRITE, 1, 8'h33, 8'h00, 1'b0, 8'h81, 0, 0, 1'b0};
        vecs[4] = '{7'h05, I2C_RW_WRITE, 2, 8'h3C, 8'h00, 1'b1, 8'h4D, 2, 0, 1'b1};
        vecs[5] = '{7'h05, I2C_RW_READ,  2, 8'h00, 8'h00, 1'b1, 8'h4D, 0, 2, 1'b1};
        vecs[6] = '{7'h04, I2C_RW_READ,  1, 8'hAA, 8'h00, 1'b0, 8'h4D, 0, 0, 1'b0};

        rst     = 1'b1;
        en      = 1'b1;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        tx_data = 8'h00;
        hold(4);
        rst = 1'b0;
        hold(2);
        check("reset.sda_oe", sda_oe, 1'b0);
        check("reset.tx_req", tx_req, 1'b0);
        check("reset.rx_valid", rx_valid, 1'b0);
        check("reset.busy", busy, 1'b0);
        check("reset.rx_data", rx_data, 8'h00);
        model_rx = 8'h00;

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 4; k++) begin
                wr_buf[k] = vecs[v].d0 + 8'(k * 17);
                tx_buf[k] = vecs[v].d0 + 8'(k * 17);
            end
            run_check($sformatf("vec%0d", v), vecs[v].addr, vecs[v].rw, vecs[v].n, vecs[v].exp_aack,
                      vecs[v].exp_rx, vecs[v].exp_rxv, vecs[v].exp_txr, vecs[v].exp_busy);
            if (vecs[v].exp_aack && vecs[v].rw == I2C_RW_READ)
                check($sformatf("vec%0d.rd0_const", v), rd_buf[0], vecs[v].exp_rd0);
            model_rx = vecs[v].exp_rx;
        end

        for (int t = 0; t < 10; t++) begin
            logic [6:0] a;
            logic       rw;
            int         n;
            logic       ea;
            a  = ($urandom_range(0, 2) == 0) ? 7'($urandom) : OWN;
            rw = 1'($urandom);
            n  = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                wr_buf[k] = 8'($urandom);
                tx_buf[k] = 8'($urandom);
            end
            ea = (a == OWN) && (a != 7'h00);
            if (ea && rw == I2C_RW_WRITE) model_rx = wr_buf[n - 1];
            run_check($sformatf("rnd%0d", t), a, rw, n, ea, model_rx,
                      (ea && rw == I2C_RW_WRITE) ? n : 0, (ea && rw == I2C_RW_READ) ? n : 0, ea);
        end

        // write then repeated START into a 3-byte read
        rxv0 = n_rxv;
        txr0 = n_txr;
        wr_buf[0] = 8'hF6;
        tx_buf[0] = 8'h12;
        xfer(OWN, I2C_RW_WRITE, 1, 1'b0, aack, wacks, bsy);
        check("rs.wr_aack", aack, 1'b1);
        tx_buf[0] = 8'h12;
        tx_buf[1] = 8'h34;
        tx_buf[2] = 8'h56;
        tx_buf[3] = 8'h78;
        xfer(OWN, I2C_RW_READ, 3, 1'b1, aack, wacks, bsy);
        check("rs.rd_aack", aack, 1'b1);
        check("rs.rx_data", rx_data, 8'hF6);
        check("rs.rx_valid_cnt", n_rxv - rxv0, 1);
        check("rs.tx_req_cnt", n_txr - txr0, 3);
        check("rs.rd0", rd_buf[0], 8'h12);
        check("rs.rd1", rd_buf[1], 8'h34);
        check("rs.rd2", rd_buf[2], 8'h56);
        model_rx = 8'hF6;

        // en dropped at bit 4 of a read byte while the slave pulls SDA low
        rxv0 = n_rxv;
        txr0 = n_txr;
        tx_data = 8'h00;
        bus_start;
        put_byte({OWN, I2C_RW_READ});
        get_bit(b);
        check("en_abort.aack", b, 1'b0);
        for (int i = 0; i < 4; i++) get_bit(b);
        check("en_abort.driving", sda_oe, 1'b1);
        en = 1'b0;
        hold(2);
        check("en_abort.sda_oe", sda_oe, 1'b0);
        check("en_abort.busy", busy, 1'b0);
        en = 1'b1;
        bus_stop;
        check("en_abort.rx_valid_cnt", n_rxv - rxv0, 0);
        check("en_abort.tx_req_cnt", n_txr - txr0, 1);
        wr_buf[0] = 8'hAA;
        model_rx  = 8'hAA;
        run_check("after_en", OWN, I2C_RW_WRITE, 1, 1'b1, model_rx, 1, 0, 1'b1);

        // rst at bit 4 of a write byte
        rxv0 = n_rxv;
        bus_start;
        put_byte({OWN, I2C_RW_WRITE});
        get_bit(b);
        check("rst_abort.aack", b, 1'b0);
        for (int i = 0; i < 4; i++) put_bit(1'b0);
        rst = 1'b1;
        hold(2);
        rst = 1'b0;
        hold(2);
        check("rst_abort.rx_data", rx_data, 8'h00);
        check("rst_abort.sda_oe", sda_oe, 1'b0);
        check("rst_abort.busy", busy, 1'b0);
        bus_stop;
        check("rst_abort.rx_valid_cnt", n_rxv - rxv0, 0);
        wr_buf[0] = 8'hAA;
        model_rx  = 8'hAA;
        run_check("after_rst", OWN, I2C_RW_WRITE, 1, 1'b1, model_rx, 1, 0, 1'b1);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // single-clk SDA spikes while SCL is high must not look like STOP/START
        rxv0 = n_rxv;
        gl   = 8'h5A;
        bus_start;
        put_byte({OWN, I2C_RW_WRITE});
        get_bit(b);
        check("glitch.aack", b, 1'b0);
        put_bit_glitch(gl[7]);
        put_bit_glitch(gl[6]);
        for (int i = 5; i >= 0; i--) put_bit(gl[i]);
        get_bit(b);
        check("glitch.dack", b, 1'b0);
        bus_stop;
        check("glitch.rx_data", rx_data, 8'h5A);
        check("glitch.rx_valid_cnt", n_rxv - rxv0, 1);
`else
        gl = 8'h00;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
